wb_unified_mem_arbiter: RTL and testbench
=========================================

Name: wb_unified_mem_arbiter

Overview:
Shares one Wishbone classic slave port (unified instruction/data memory) between the core's instruction bus (iwb) and data bus (dwb). Grant is registered and held for a whole bus cycle. Data has fixed priority, bounded by an anti-starvation limit. A per-transaction watchdog returns err when the slave never answers. Sits between custom_riscv_core and the unified memory or bus fabric.

Parameters:
ADDR_W, 32, address width on all ports
MAX_D_CONSEC, 4, max back-to-back dwb grants while iwb waits; next grant is then forced to iwb (0 = pure data priority)
TIMEOUT_CYCLES, 255, cycles of stb without ack/err before watchdog err (0 = watchdog disabled); counter 8 bits

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
iwb_adr_i  in  ADDR_W  fetch address
iwb_cyc_i  in  1  fetch cycle
iwb_stb_i  in  1  fetch strobe
iwb_dat_o  out  32  fetch read data
iwb_ack_o  out  1  fetch ack
iwb_err_o  out  1  fetch error
dwb_adr_i  in  ADDR_W  data address
dwb_dat_i  in  32  store data
dwb_we_i  in  1  write enable
dwb_sel_i  in  4  byte selects
dwb_cyc_i  in  1  data cycle
dwb_stb_i  in  1  data strobe
dwb_dat_o  out  32  load data
dwb_ack_o  out  1  data ack
dwb_err_o  out  1  data error
m_adr_o  out  ADDR_W  slave address
m_dat_o  out  32  slave write data
m_we_o  out  1  slave write enable
m_sel_o  out  4  slave byte selects
m_cyc_o  out  1  slave cycle
m_stb_o  out  1  slave strobe
m_dat_i  in  32  slave read data
m_ack_i  in  1  slave ack
m_err_i  in  1  slave error
grant_o  out  2  {d_granted, i_granted}, debug/trace

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. Reset (async, rst=1) forces IDLE, consecutive-D counter = 0, watchdog = 0. While in IDLE, every output is 0.
- Arbitration happens in IDLE only, using requests req_i = iwb_cyc_i & iwb_stb_i and req_d = dwb_cyc_i & dwb_stb_i.
  - Only req_d: go to GNT_D.
  - Only req_i: go to GNT_I.
  - Both: go to GNT_D, unless MAX_D_CONSEC != 0 and d_consec == MAX_D_CONSEC; then go to GNT_I.
- d_consec:
  - Increments on each IDLE->GNT_D taken while req_i is high.
  - Clears on any IDLE->GNT_I, or on IDLE->GNT_D with req_i low.
  - Saturates at MAX_D_CONSEC.
- Latency: one arbitration cycle. A request seen in IDLE at edge N gives m_cyc_o/m_stb_o high from edge N+1.
- Granted routing is combinational from state:
  - m_* outputs mirror the granted master.
  - For iwb: m_we_o = 0, m_sel_o = 4'hF, m_dat_o = 0.
  - m_cyc_o follows the master's cyc; m_stb_o follows the master's stb.
- Response routing:
  - m_dat_i goes to both dat_o outputs.
  - ack/err reach only the granted master; the other master sees 0.
  - Any m_ack_i/m_err_i arriving in IDLE is dropped.
- Release: the granted master's cyc low at a clock edge returns the FSM to IDLE. Minimum one IDLE bubble between grants. A master abort (cyc dropped before ack) is legal; a late ack is discarded.
- Watchdog (TIMEOUT_CYCLES != 0):
  - Counts cycles in a GNT state with m_stb_o=1 and m_ack_i=m_err_i=0.
  - Clears on ack, on err, or on leaving the GNT state.
  - When the count reaches TIMEOUT_CYCLES, the granted master's err output pulses high for exactly 1 cycle. In that same cycle m_stb_o is forced 0, and the FSM goes to IDLE at the next edge regardless of cyc.
  - Simultaneous m_ack_i and timeout in the same cycle: ack wins, no err.
  - m_ack_i and m_err_i both high: forward both; the master treats err as dominant.
- Reset asserted mid-transaction: outputs drop to 0 immediately (async). The slave must tolerate the abandoned cycle.

Decomposition:
- Shared header riscv_defines.vh gains ARB_IDLE/ARB_GNT_I/ARB_GNT_D state encodings and the default timeout value.
- One natural sub-module, wb_watchdog_counter: enable, clear, limit compare, one-cycle expire pulse. All else stays in the top.

Test Plan:
- Lone fetch: iwb req to address 0x100, slave acks 1 cycle after stb, data 0x00000013 -> grant_o=01 one cycle after req; iwb_ack_o=1 with iwb_dat_o=0x13; dwb_ack_o stays 0; back to IDLE after cyc drops.
- Simultaneous req, store to 0x1000 with data 0x1 and sel 4'hF: -> D served first (m_we_o=1, m_dat_o=0x1); I granted after a one-cycle IDLE bubble; iwb never sees an ack during the D grant.
- Starvation limit (MAX_D_CONSEC=2): dwb requests continuously, iwb held pending -> grant sequence is D, D, I, D, D, I.
- Watchdog (TIMEOUT_CYCLES=8): slave never acks a dwb load -> dwb_err_o pulses exactly once, 8 cycles after grant; FSM returns to IDLE; a following iwb fetch completes normally.
- Abort plus late ack: iwb drops cyc before ack, slave acks 1 cycle later -> late ack is not seen on iwb_ack_o or dwb_ack_o; next dwb request is granted normally.
- Reset mid-D-transaction: rst pulsed high while m_stb_o=1 -> m_cyc_o, m_stb_o and all acks go 0 within the same cycle; grant_o=00; first request after reset is granted after one arbitration cycle.

Source files
------------

// File: rtl/wb_unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package wb_unified_mem_arbiter_pkg;

  // Arbiter FSM encodings: idle/arbitrate, fetch bus granted, data bus granted.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  // Default watchdog limit in stalled strobe cycles, and the watchdog counter width.
  localparam int unsigned ARB_DEFAULT_TIMEOUT = 255;
  localparam int unsigned WD_CNT_W            = 8;

  // Counter width used to track back-to-back data grants.
  localparam int unsigned DCONSEC_W = 8;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] IWB_SEL = 4'hF;

endpackage

// File: rtl/wb_watchdog_counter.sv
// Per-transaction watchdog: counts stalled strobe cycles and raises a
// one-cycle expire pulse when the count reaches LIMIT (LIMIT = 0 disables it).
module wb_watchdog_counter
  import wb_unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = ARB_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [WD_CNT_W-1:0] LIMIT_C = WD_CNT_W'(LIMIT);

  logic [WD_CNT_W-1:0] count;

  // Count stalled cycles, holding at the limit until the grant is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT_C)) begin
      count <= count + 1'b1;
    end
  end

  // Expire only during a still-stalled cycle, so a same-cycle ack wins.
  assign expire = (LIMIT != 0) && en && (count == LIMIT_C);

endmodule

// File: rtl/wb_unified_mem_arbiter.sv
// Shares one Wishbone classic slave port between the fetch (iwb) and data
// (dwb) buses. Data has priority, bounded by an anti-starvation limit, and a
// watchdog terminates cycles the slave never answers.
module wb_unified_mem_arbiter
  import wb_unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned MAX_D_CONSEC   = 4,
  parameter int unsigned TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] iwb_adr_i,
  input  logic              iwb_cyc_i,
  input  logic              iwb_stb_i,
  output logic [31:0]       iwb_dat_o,
  output logic              iwb_ack_o,
  output logic              iwb_err_o,
  input  logic [ADDR_W-1:0] dwb_adr_i,
  input  logic [31:0]       dwb_dat_i,
  input  logic              dwb_we_i,
  input  logic [3:0]        dwb_sel_i,
  input  logic              dwb_cyc_i,
  input  logic              dwb_stb_i,
  output logic [31:0]       dwb_dat_o,
  output logic              dwb_ack_o,
  output logic              dwb_err_o,
  output logic [ADDR_W-1:0] m_adr_o,
  output logic [31:0]       m_dat_o,
  output logic              m_we_o,
  output logic [3:0]        m_sel_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  input  logic [31:0]       m_dat_i,
  input  logic              m_ack_i,
  input  logic              m_err_i,
  output logic [1:0]        grant_o
);

  localparam logic [DCONSEC_W-1:0] MAX_D_C = DCONSEC_W'(MAX_D_CONSEC);

  arb_state_t           state;
  arb_state_t           state_next;
  logic [DCONSEC_W-1:0] d_consec;
  logic [DCONSEC_W-1:0] d_consec_next;
  logic                 req_i;
  logic                 req_d;
  logic                 d_limit_hit;
  logic                 granted;
  logic                 sel_stb;
  logic                 stalled;
  logic                 wd_clr;
  logic                 wd_expire;

  assign req_i       = iwb_cyc_i & iwb_stb_i;
  assign req_d       = dwb_cyc_i & dwb_stb_i;
  assign d_limit_hit = (MAX_D_CONSEC != 0) && (d_consec == MAX_D_C);
  assign granted     = (state == ARB_GNT_I) || (state == ARB_GNT_D);

  // The granted master's raw strobe drives the watchdog, independent of the forced m_stb_o.
  assign sel_stb = ((state == ARB_GNT_I) & iwb_stb_i) | ((state == ARB_GNT_D) & dwb_stb_i);
  assign stalled = sel_stb & ~m_ack_i & ~m_err_i;
  assign wd_clr  = ~granted | m_ack_i | m_err_i;

  wb_watchdog_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .en     (stalled),
    .clr    (wd_clr),
    .expire (wd_expire)
  );

  // State register and back-to-back data grant counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      d_consec <= '0;
    end else begin
      state    <= state_next;
      d_consec <= d_consec_next;
    end
  end

  // Arbitration, release and bus/response routing from the current grant.
  always_comb begin
    state_next    = state;
    d_consec_next = d_consec;
    m_adr_o       = '0;
    m_dat_o       = '0;
    m_we_o        = 1'b0;
    m_sel_o       = '0;
    m_cyc_o       = 1'b0;
    m_stb_o       = 1'b0;
    iwb_dat_o     = '0;
    iwb_ack_o     = 1'b0;
    iwb_err_o     = 1'b0;
    dwb_dat_o     = '0;
    dwb_ack_o     = 1'b0;
    dwb_err_o     = 1'b0;
    grant_o       = 2'b00;

    case (state)
      ARB_IDLE: begin
        if (req_d && !(req_i && d_limit_hit)) begin
          state_next = ARB_GNT_D;
          if (!req_i) begin
            d_consec_next = '0;
          end else if (d_consec != MAX_D_C) begin
            d_consec_next = d_consec + 1'b1;
          end
        end else if (req_i) begin
          state_next    = ARB_GNT_I;
          d_consec_next = '0;
        end
      end

      ARB_GNT_I: begin
        m_adr_o   = iwb_adr_i;
        m_sel_o   = IWB_SEL;
        m_cyc_o   = iwb_cyc_i;
        m_stb_o   = iwb_stb_i & ~wd_expire;
        iwb_dat_o = m_dat_i;
        dwb_dat_o = m_dat_i;
        iwb_ack_o = m_ack_i;
        iwb_err_o = m_err_i | wd_expire;
        grant_o   = 2'b01;
        if (!iwb_cyc_i || wd_expire) begin
          state_next = ARB_IDLE;
        end
      end

      ARB_GNT_D: begin
        m_adr_o   = dwb_adr_i;
        m_dat_o   = dwb_dat_i;
        m_we_o    = dwb_we_i;
        m_sel_o   = dwb_sel_i;
        m_cyc_o   = dwb_cyc_i;
        m_stb_o   = dwb_stb_i & ~wd_expire;
        iwb_dat_o = m_dat_i;
        dwb_dat_o = m_dat_i;
        dwb_ack_o = m_ack_i;
        dwb_err_o = m_err_i | wd_expire;
        grant_o   = 2'b10;
        if (!dwb_cyc_i || wd_expire) begin
          state_next = ARB_IDLE;
        end
      end

      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Directed bench for wb_unified_mem_arbiter: a table of per-cycle vectors
// followed by hand-written multi-cycle sequences.
module tb_wb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] iwb_adr_i;
  logic        iwb_cyc_i;
  logic        iwb_stb_i;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o;
  logic        iwb_err_o;
  logic [31:0] dwb_adr_i;
  logic [31:0] dwb_dat_i;
  logic        dwb_we_i;
  logic [3:0]  dwb_sel_i;
  logic        dwb_cyc_i;
  logic        dwb_stb_i;
  logic [31:0] dwb_dat_o;
  logic        dwb_ack_o;
  logic        dwb_err_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;
  logic        m_err_i;
  logic [1:0]  grant_o;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic        ireq;
    logic [31:0] ia;
    logic        dreq;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [3:0]  dsel;
    logic        sa;
    logic        se;
    logic [31:0] sd;
    logic [12:0] ectl;
    logic [31:0] eadr;
    logic [31:0] ewdat;
    logic [31:0] erdat;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  wb_unified_mem_arbiter #(
    .ADDR_W         (32),
    .MAX_D_CONSEC   (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iwb_adr_i (iwb_adr_i),
    .iwb_cyc_i (iwb_cyc_i),
    .iwb_stb_i (iwb_stb_i),
    .iwb_dat_o (iwb_dat_o),
    .iwb_ack_o (iwb_ack_o),
    .iwb_err_o (iwb_err_o),
    .dwb_adr_i (dwb_adr_i),
    .dwb_dat_i (dwb_dat_i),
    .dwb_we_i  (dwb_we_i),
    .dwb_sel_i (dwb_sel_i),
    .dwb_cyc_i (dwb_cyc_i),
    .dwb_stb_i (dwb_stb_i),
    .dwb_dat_o (dwb_dat_o),
    .dwb_ack_o (dwb_ack_o),
    .dwb_err_o (dwb_err_o),
    .m_adr_o   (m_adr_o),
    .m_dat_o   (m_dat_o),
    .m_we_o    (m_we_o),
    .m_sel_o   (m_sel_o),
    .m_cyc_o   (m_cyc_o),
    .m_stb_o   (m_stb_o),
    .m_dat_i   (m_dat_i),
    .m_ack_i   (m_ack_i),
    .m_err_i   (m_err_i),
    .grant_o   (grant_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word: {grant, cyc, stb, we, sel, iack, ierr, dack, derr}.
  function automatic logic [12:0] c(logic [1:0] g, logic cy, logic st, logic we,
                                    logic [3:0] sel, logic ia, logic ie, logic da, logic de);
    return {g, cy, st, we, sel, ia, ie, da, de};
  endfunction

  function automatic vec_t mk(logic ireq, logic [31:0] ia, logic dreq, logic dw,
                              logic [31:0] da, logic [31:0] dd, logic [3:0] dsel,
                              logic sa, logic se, logic [31:0] sd, logic [12:0] ectl,
                              logic [31:0] eadr, logic [31:0] ewdat, logic [31:0] erdat);
    vec_t v;
    v.ireq = ireq; v.ia = ia; v.dreq = dreq; v.dw = dw; v.da = da; v.dd = dd;
    v.dsel = dsel; v.sa = sa; v.se = se; v.sd = sd; v.ectl = ectl;
    v.eadr = eadr; v.ewdat = ewdat; v.erdat = erdat;
    return v;
  endfunction

  function automatic logic [12:0] actCtl();
    return {grant_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
            iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o};
  endfunction

  task automatic applyStimulus(input vec_t v);
    iwb_cyc_i = v.ireq; iwb_stb_i = v.ireq; iwb_adr_i = v.ia;
    dwb_cyc_i = v.dreq; dwb_stb_i = v.dreq; dwb_we_i = v.dw;
    dwb_adr_i = v.da;   dwb_dat_i = v.dd;   dwb_sel_i = v.dsel;
    m_ack_i   = v.sa;   m_err_i   = v.se;   m_dat_i   = v.sd;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    applyStimulus(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 13'h0, 32'h0, 32'h0, 32'h0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Lone fetch.
    tbl[0]  = mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 4'h0, 0, 0, 32'hDEADBEEF,
                 c(2'b00,0,0,0,4'h0,0,0,0,0), 32'h0,    32'h0, 32'h0);
    tbl[1]  = mk(1, 32'h100, 0, 0, 32'h0,    32'h0, 4'h0, 0, 0, 32'h0,
                 c(2'b00,0,0,0,4'h0,0,0,0,0), 32'h0,    32'h0, 32'h0);
    tbl[2]  = mk(1, 32'h100, 0, 0, 32'h0,    32'h0, 4'h0, 0, 0, 32'h0,
                 c(2'b01,1,1,0,4'hF,0,0,0,0), 32'h100,  32'h0, 32'h0);
    tbl[3]  = mk(1, 32'h100, 0, 0, 32'h0,    32'h0, 4'h0, 1, 0, 32'h13,
                 c(2'b01,1,1,0,4'hF,1,0,0,0), 32'h100,  32'h0, 32'h13);
    tbl[4]  = mk(0, 32'h100, 0, 0, 32'h0,    32'h0, 4'h0, 0, 0, 32'h0,
                 c(2'b01,0,0,0,4'hF,0,0,0,0), 32'h100,  32'h0, 32'h0);
    tbl[5]  = mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 4'h0, 0, 0, 32'h0,
                 c(2'b00,0,0,0,4'h0,0,0,0,0), 32'h0,    32'h0, 32'h0);
    // Simultaneous requests: store served first, fetch after an idle bubble.
    tbl[6]  = mk(1, 32'h200, 1, 1, 32'h1000, 32'h1, 4'hF, 0, 0, 32'h0,
                 c(2'b00,0,0,0,4'h0,0,0,0,0), 32'h0,    32'h0, 32'h0);
    tbl[7]  = mk(1, 32'h200, 1, 1, 32'h1000, 32'h1, 4'hF, 0, 0, 32'h0,
                 c(2'b10,1,1,1,4'hF,0,0,0,0), 32'h1000, 32'h1, 32'h0);
    tbl[8]  = mk(1, 32'h200, 1, 1, 32'h1000, 32'h1, 4'hF, 1, 0, 32'h0,
                 c(2'b10,1,1,1,4'hF,0,0,1,0), 32'h1000, 32'h1, 32'h0);
    tbl[9]  = mk(1, 32'h200, 0, 1, 32'h1000, 32'h1, 4'hF, 0, 0, 32'h0,
                 c(2'b10,0,0,1,4'hF,0,0,0,0), 32'h1000, 32'h1, 32'h0);
    tbl[10] = mk(1, 32'h200, 0, 1, 32'h1000, 32'h1, 4'hF, 0, 0, 32'h0,
                 c(2'b00,0,0,0,4'h0,0,0,0,0), 32'h0,    32'h0, 32'h0);
    tbl[11] = mk(1, 32'h200, 0, 0, 32'h0,    32'h0, 4'h0, 1, 0, 32'h55,
                 c(2'b01,1,1,0,4'hF,1,0,0,0), 32'h200,  32'h0, 32'h55);
    tbl[12] = mk(0, 32'h200, 0, 0, 32'h0,    32'h0, 4'h0, 0, 0, 32'h0,
                 c(2'b01,0,0,0,4'hF,0,0,0,0), 32'h200,  32'h0, 32'h0);
    tbl[13] = mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 4'h0, 0, 0, 32'h0,
                 c(2'b00,0,0,0,4'h0,0,0,0,0), 32'h0,    32'h0, 32'h0);
    // Data read with both ack and err from the slave, then a response in idle.
    tbl[14] = mk(0, 32'h0,   1, 0, 32'h300,  32'h0, 4'h3, 0, 0, 32'h0,
                 c(2'b00,0,0,0,4'h0,0,0,0,0), 32'h0,    32'h0, 32'h0);
    tbl[15] = mk(0, 32'h0,   1, 0, 32'h300,  32'h0, 4'h3, 1, 1, 32'hAA,
                 c(2'b10,1,1,0,4'h3,0,0,1,1), 32'h300,  32'h0, 32'hAA);
    tbl[16] = mk(0, 32'h0,   0, 0, 32'h300,  32'h0, 4'h3, 0, 0, 32'h0,
                 c(2'b10,0,0,0,4'h3,0,0,0,0), 32'h300,  32'h0, 32'h0);
    tbl[17] = mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 4'h0, 1, 1, 32'h77,
                 c(2'b00,0,0,0,4'h0,0,0,0,0), 32'h0,    32'h0, 32'h0);

    rst = 1'b1;
    clearInputs();
    iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    #3;
    checkOutput("in_reset", 64'(actCtl()), 64'(13'h0));
    clearInputs();
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(tbl[i]);
      #2;
      checkOutput($sformatf("vec%0d_ctl", i),  64'(actCtl()), 64'(tbl[i].ectl));
      checkOutput($sformatf("vec%0d_adr", i),  64'(m_adr_o),  64'(tbl[i].eadr));
      checkOutput($sformatf("vec%0d_wdat", i), 64'(m_dat_o),  64'(tbl[i].ewdat));
      checkOutput($sformatf("vec%0d_rdat", i), {iwb_dat_o, dwb_dat_o}, {tbl[i].erdat, tbl[i].erdat});
      step();
    end

    // Starvation limit of 2: D, D, I, D, D, I.
    clearInputs();
    for (int r = 0; r < 6; r++) begin
      logic [1:0] expG;
      expG = ((r % 3) == 2) ? 2'b01 : 2'b10;
      iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1; iwb_adr_i = 32'h900;
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_adr_i = 32'hA00;
      m_ack_i = 1'b0;
      #2;
      checkOutput($sformatf("starve_idle%0d", r), 64'(grant_o), 64'(2'b00));
      step();
      m_ack_i = 1'b1;
      #2;
      checkOutput($sformatf("starve_gnt%0d", r), 64'(grant_o), 64'(expG));
      step();
      m_ack_i = 1'b0;
      if (expG == 2'b10) begin
        dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
      end else begin
        iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      end
      step();
    end

    // Watchdog: data load the slave never answers.
    clearInputs();
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_adr_i = 32'h500;
    #2;
    checkOutput("wd_arb", 64'(grant_o), 64'(2'b00));
    step();
    for (int k = 0; k <= 8; k++) begin
      #2;
      checkOutput($sformatf("wd_err%0d", k), 64'(dwb_err_o), 64'(k == 8));
      checkOutput($sformatf("wd_stb%0d", k), 64'(m_stb_o),   64'(k != 8));
      if (k == 8) begin
        checkOutput("wd_cyc_held", 64'({grant_o, m_cyc_o, iwb_err_o}), 64'({2'b10, 1'b1, 1'b0}));
      end
      step();
    end
    #2;
    checkOutput("wd_release", 64'({grant_o, dwb_err_o}), 64'({2'b00, 1'b0}));
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1; iwb_adr_i = 32'h600;
    step();
    m_ack_i = 1'b1; m_dat_i = 32'h13;
    #2;
    checkOutput("wd_fetch", 64'({grant_o, iwb_ack_o, iwb_err_o, iwb_dat_o}),
                64'({2'b01, 1'b1, 1'b0, 32'h13}));
    step();
    clearInputs();
    step();

    // Fetch abort followed by a late ack, then a normal data grant.
    iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1; iwb_adr_i = 32'h400;
    step();
    #2;
    checkOutput("abort_gnt", 64'(grant_o), 64'(2'b01));
    step();
    iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    #2;
    checkOutput("abort_cyc", 64'({m_cyc_o, m_stb_o}), 64'(2'b00));
    step();
    m_ack_i = 1'b1;
    #2;
    checkOutput("late_ack", 64'(actCtl()), 64'(13'h0));
    step();
    m_ack_i = 1'b0;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_adr_i = 32'h700;
    #2;
    checkOutput("post_abort_idle", 64'(grant_o), 64'(2'b00));
    step();
    m_ack_i = 1'b1;
    #2;
    checkOutput("post_abort_d", 64'({grant_o, dwb_ack_o, iwb_ack_o, m_adr_o}),
                64'({2'b10, 1'b1, 1'b0, 32'h700}));
    step();
    clearInputs();
    step();

    // Asynchronous reset in the middle of a data transaction.
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_we_i = 1'b1;
    dwb_adr_i = 32'h800; dwb_dat_i = 32'h12; dwb_sel_i = 4'hF;
    step();
    #2;
    checkOutput("rst_pre", 64'({grant_o, m_cyc_o, m_stb_o}), 64'({2'b10, 1'b1, 1'b1}));
    m_ack_i = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid", 64'(actCtl()), 64'(13'h0));
    clearInputs();
    #1;
    rst = 1'b0;
    step();
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_adr_i = 32'h804;
    #2;
    checkOutput("rst_arb", 64'(grant_o), 64'(2'b00));
    step();
    #2;
    checkOutput("rst_regrant", 64'({grant_o, m_stb_o, m_adr_o}), 64'({2'b10, 1'b1, 32'h804}));
    step();
    clearInputs();
    step();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
